signed_addsub_8: RTL and testbench

Registered two's-complement adder/subtractor for the computational core. It forms ±A ±B on two signed N-bit operands, with the operand signs chosen by a 2-bit control. The wrapped N-bit result and a signed-overflow flag are presented one clock later. It sits between the operand registers and the result bus; no handshake is used.

---
 rtl/signed_addsub_8.sv | 79 +++++++
 tb/tb_signed_addsub_8.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/signed_addsub_8.sv
// signed_addsub_8
//   Registered two's-complement adder/subtractor: res = (+/-)A (+/-)B.
//   The two operand negations become XOR conditioning plus carry-in
//   corrections into a single (N+2)-bit adder. The wrapped N-bit result and
//   a signed-overflow flag are registered, so they appear one cycle later.
//
// Ports
//   clk         system clock, rising edge
//   rst         asynchronous active-high reset; clears res_signed and ovf
//   a, b        signed N-bit operands
//   sign        sign[1] negates A, sign[0] negates B
//   res_signed  registered result, wrapped modulo 2^N
//   ovf         registered flag: exact result outside the N-bit signed range

// Per-operand conditioning. This stage forms the one's complement when the
// operand is negated, then sign-extends it to N+2 bits. The missing +1 is
// supplied later as a carry-in.
module addsub_operand_cond #(
  parameter int N = 8
) (
  input  logic [N-1:0] opnd,
  input  logic         neg,
  output logic [N+1:0] cond
);
  logic [N-1:0] inv;

  assign inv  = opnd ^ {N{neg}};
  assign cond = {{2{inv[N-1]}}, inv};
endmodule

module signed_addsub_8 #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   sign,
  output logic [N-1:0] res_signed,
  output logic         ovf
);
  // Index 1 is A and index 0 is B, so that sign[i] lines up with the operand
  // it negates.
  logic [1:0][N-1:0] ops;
  logic [1:0][N+1:0] cond;
  logic [N+1:0]      cin;
  logic [N+1:0]      sum;
  logic              ovf_next;

  assign ops = {a, b};

  for (genvar i = 0; i < 2; i++) begin : g_op
    addsub_operand_cond #(.N(N)) u_cond (
      .opnd (ops[i]),
      .neg  (sign[i]),
      .cond (cond[i])
    );
  end

  // Both +1 corrections are folded into one small constant:
  // sign[1] + sign[0] = {and, xor}, which is at most 2.
  assign cin = {{N{1'b0}}, sign[1] & sign[0], sign[1] ^ sign[0]};

  // The exact result lies in -2^N..2^N, so N+2 bits never wrap.
  assign sum = cond[1] + cond[0] + cin;

  // The result fits in N signed bits only when the top three bits agree.
  assign ovf_next = !((sum[N+1:N-1] == 3'b000) || (sum[N+1:N-1] == 3'b111));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_signed <= '0;
      ovf        <= 1'b0;
    end else begin
      res_signed <= sum[N-1:0];
      ovf        <= ovf_next;
    end
  end
endmodule

// File: tb/tb_signed_addsub_8.sv
module tb_signed_addsub_8;
  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic [1:0] sign;
  logic [7:0] res_signed;
  logic       ovf;

  int n_chk;
  int n_fail;

  signed_addsub_8 #(.N(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .b          (b),
    .sign       (sign),
    .res_signed (res_signed),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one vector at a negedge, then check the registered result #1 after
  // the following posedge.
  task automatic apply(input logic [7:0] va, input logic [7:0] vb, input logic [1:0] vs);
    @(negedge clk);
    a = va; b = vb; sign = vs;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; a = 8'hF2; b = 8'hE7; sign = 2'd0;
    #1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_chk++;
      if (res_signed !== 8'h00 || ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: got res=%h ovf=%b want res=00 ovf=0", i, res_signed, ovf);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (res_signed !== 8'hD9 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: got res=%h ovf=%b want res=d9 ovf=0", res_signed, ovf);
    end
  endtask

  // The four sign settings on -14 and -25, applied back to back.
  task automatic test_ops();
    logic [7:0] exp_r [4];
    exp_r[0] = 8'hD9; exp_r[1] = 8'h0B; exp_r[2] = 8'hF5; exp_r[3] = 8'h27;
    for (int s = 0; s < 4; s++) begin
      apply(8'hF2, 8'hE7, 2'(s));
      n_chk++;
      if (res_signed !== exp_r[s] || ovf !== 1'b0) begin
        n_fail++;
        $display("FAIL ops sign=%0d: got res=%h ovf=%b want res=%h ovf=0", s, res_signed, ovf, exp_r[s]);
      end
    end
  endtask

  task automatic test_overflow();
    logic [7:0] va [6];
    logic [7:0] vb [6];
    logic [1:0] vs [6];
    logic [7:0] er [6];
    logic       eo [6];
    va[0]=8'h7F; vb[0]=8'h01; vs[0]=2'd0; er[0]=8'h80; eo[0]=1'b1;
    va[1]=8'h80; vb[1]=8'h01; vs[1]=2'd1; er[1]=8'h7F; eo[1]=1'b1;
    va[2]=8'h80; vb[2]=8'h80; vs[2]=2'd3; er[2]=8'h00; eo[2]=1'b1;
    va[3]=8'h80; vb[3]=8'h00; vs[3]=2'd2; er[3]=8'h80; eo[3]=1'b1;
    va[4]=8'h80; vb[4]=8'h01; vs[4]=2'd2; er[4]=8'h81; eo[4]=1'b1;
    va[5]=8'h80; vb[5]=8'hFF; vs[5]=2'd2; er[5]=8'h7F; eo[5]=1'b0;
    for (int i = 0; i < 6; i++) begin
      apply(va[i], vb[i], vs[i]);
      n_chk++;
      if (res_signed !== er[i] || ovf !== eo[i]) begin
        n_fail++;
        $display("FAIL ovf_vec%0d a=%h b=%h s=%0d: got res=%h ovf=%b want res=%h ovf=%b",
                 i, va[i], vb[i], vs[i], res_signed, ovf, er[i], eo[i]);
      end
    end
  endtask

  // Input changes between edges must not reach the outputs early.
  task automatic test_hold_between_edges();
    apply(8'h10, 8'h05, 2'd0);
    a = 8'h7F; b = 8'h7F; sign = 2'd0;
    #2;
    n_chk++;
    if (res_signed !== 8'h15 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_between_edges: got res=%h ovf=%b want res=15 ovf=0", res_signed, ovf);
    end
    @(posedge clk); #1;
    n_chk++;
    if (res_signed !== 8'hFE || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_next_edge: got res=%h ovf=%b want res=fe ovf=1", res_signed, ovf);
    end
  endtask

  task automatic test_async_reset();
    apply(8'hF2, 8'hE7, 2'd3);
    n_chk++;
    if (res_signed !== 8'h27) begin
      n_fail++;
      $display("FAIL async_pre: got res=%h want res=27", res_signed);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (res_signed !== 8'h00 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL async_assert: got res=%h ovf=%b want res=00 ovf=0", res_signed, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_chk++;
    if (res_signed !== 8'h27 || ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL async_release: got res=%h ovf=%b want res=27 ovf=0", res_signed, ovf);
    end
  endtask

  task automatic test_random();
    int         ea, eb, ex;
    logic [7:0] er;
    logic       eo;
    logic [7:0] va, vb;
    logic [1:0] vs;
    for (int i = 0; i < 10000; i++) begin
      va = 8'($urandom); vb = 8'($urandom); vs = 2'($urandom);
      ea = int'($signed(va));
      eb = int'($signed(vb));
      ex = (vs[1] ? -ea : ea) + (vs[0] ? -eb : eb);
      er = 8'(ex);
      eo = (ex > 127) || (ex < -128);
      apply(va, vb, vs);
      n_chk++;
      if (res_signed !== er || ovf !== eo) begin
        n_fail++;
        $display("FAIL random%0d a=%h b=%h s=%0d: got res=%h ovf=%b want res=%h ovf=%b",
                 i, va, vb, vs, res_signed, ovf, er, eo);
      end
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    test_reset();
    test_ops();
    test_overflow();
    test_hold_between_edges();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
